// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the memory request arbiter:
//   - transaction kind codes (fetch / load / store)
//   - access size codes
//   - arbiter FSM state encoding
//   - default starvation limit for the optional fetch anti-starvation guard
//   - one-hot grant bit positions used between the picker and the top level
// -----------------------------------------------------------------------------
package mem_arb_pkg;

   typedef enum logic [1:0] {
      KIND_FETCH = 2'b00,
      KIND_LOAD  = 2'b01,
      KIND_STORE = 2'b10
   } mem_kind_e;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_WAIT  = 2'b10,
      ST_DRAIN = 2'b11
   } arb_state_e;

   localparam int STARVE_LIMIT_DEF = 8;

   // Bit positions inside the one-hot grant vector.
   localparam int GNT_FET = 0;
   localparam int GNT_LD  = 1;
   localparam int GNT_ST  = 2;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_req_arbiter_if
// Bundles the three requester handshakes, the memory-controller issue/complete
// signals and the per-requester completion pulses of mem_req_arbiter.
//   slave  : the arbiter's view (requests and memory status in, grants,
//            issue fields and done pulses out)
//   master : the environment's view (fetch/load/store units plus the memory
//            controller), the mirror image of slave
// Parameter ROB_W sets the width of the load ROB tag.
// -----------------------------------------------------------------------------
interface mem_req_arbiter_if #(
   parameter int ROB_W = 4
);
   // fetch requester
   logic             fet_req_valid;
   logic [31:0]      fet_req_addr;
   logic             fet_req_ready;
   // load requester
   logic             ld_req_valid;
   logic [1:0]       ld_req_size;
   logic [31:0]      ld_req_addr;
   logic [ROB_W-1:0] ld_req_id;
   logic             ld_req_ready;
   // store requester (committed stores)
   logic             st_req_valid;
   logic [1:0]       st_req_size;
   logic [31:0]      st_req_addr;
   logic [31:0]      st_req_data;
   logic             st_req_ready;
   // memory controller side
   logic             arb_mem_valid;
   logic [1:0]       arb_mem_kind;
   logic [1:0]       arb_mem_size;
   logic [31:0]      arb_mem_addr;
   logic [31:0]      arb_mem_data;
   logic [ROB_W-1:0] arb_mem_id;
   logic             mem_busy;
   logic             mem_done;
   // completion pulses and owner
   logic             fet_done;
   logic             ld_done;
   logic             st_done;
   logic [1:0]       arb_owner;

   modport slave (
      input  fet_req_valid, fet_req_addr,
      input  ld_req_valid, ld_req_size, ld_req_addr, ld_req_id,
      input  st_req_valid, st_req_size, st_req_addr, st_req_data,
      input  mem_busy, mem_done,
      output fet_req_ready, ld_req_ready, st_req_ready,
      output arb_mem_valid, arb_mem_kind, arb_mem_size,
      output arb_mem_addr, arb_mem_data, arb_mem_id,
      output fet_done, ld_done, st_done, arb_owner
   );

   modport master (
      output fet_req_valid, fet_req_addr,
      output ld_req_valid, ld_req_size, ld_req_addr, ld_req_id,
      output st_req_valid, st_req_size, st_req_addr, st_req_data,
      output mem_busy, mem_done,
      input  fet_req_ready, ld_req_ready, st_req_ready,
      input  arb_mem_valid, arb_mem_kind, arb_mem_size,
      input  arb_mem_addr, arb_mem_data, arb_mem_id,
      input  fet_done, ld_done, st_done, arb_owner
   );

endinterface

// File: rtl/mem_arb_pick.sv
// -----------------------------------------------------------------------------
// mem_arb_pick
// Combinational priority select for the memory request arbiter.
// Ports:
//   fet_valid, ld_valid, st_valid : requests eligible this cycle
//   starve                        : fetch has lost too often and outranks all
//   grant[2:0]                    : one-hot grant, bit positions GNT_* from
//                                   mem_arb_pkg; all zero when nothing is valid
// Normal order is store > load > fetch; a raised starve flag puts fetch first.
// -----------------------------------------------------------------------------
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic       fet_valid,
   input  logic       ld_valid,
   input  logic       st_valid,
   input  logic       starve,
   output logic [2:0] grant
);

   always_comb begin
      // NOTE: default every output first so no path through the if-chain
      // leaves grant unassigned (which would infer a latch).
      grant = '0;
      if (starve && fet_valid) begin
         grant[GNT_FET] = 1'b1;
      end else if (st_valid) begin
         grant[GNT_ST] = 1'b1;
      end else if (ld_valid) begin
         grant[GNT_LD] = 1'b1;
      end else if (fet_valid) begin
         grant[GNT_FET] = 1'b1;
      end
   end

endmodule

// File: rtl/mem_req_arbiter.sv
// -----------------------------------------------------------------------------
// mem_req_arbiter
// Arbitrates instruction fetch, load and committed-store requests onto a single
// memory controller port, one transaction at a time.
//
// Ports:
//   clk   : clock
//   rst   : synchronous active-high reset, wins over rdy and flush
//   rdy   : global enable; all state and the latched fields hold while low,
//           and no ready/valid/done strobe is produced
//   flush : pipeline flush; cancels fetch/load work, never stores
//   bus   : mem_req_arbiter_if.slave (requester handshakes, issue fields,
//           memory busy/done, per-requester done pulses, arb_owner)
//
// Flow: IDLE arbitrates and latches the winner -> ISSUE strobes arb_mem_valid
// on the first cycle mem_busy is low -> WAIT for mem_done, which pulses the
// owner's done -> IDLE. A flushed fetch/load in WAIT goes to DRAIN, where the
// completion is absorbed silently.
//
// Build option: define MEM_ARB_STARVE_GUARD_EN to add the fetch anti-starvation
// counter. Once fetch has lost STARVE_LIMIT arbitrations in which it was
// valid, it outranks store and load until it is granted or a flush occurs.
// Without the macro the priority is strictly store > load > fetch.
// -----------------------------------------------------------------------------
module mem_req_arbiter
   import mem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
   parameter int ROB_W        = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rdy,
   input  logic               flush,
   mem_req_arbiter_if.slave   bus
);

   arb_state_e       state_q;
   mem_kind_e        kind_q;
   logic [1:0]       size_q;
   logic [31:0]      addr_q;
   logic [31:0]      data_q;
   logic [ROB_W-1:0] id_q;

   logic       active;
   logic       fet_elig;
   logic       ld_elig;
   logic       starve;
   logic [2:0] gnt;
   logic       idle_arb;
   logic       kill;
   logic       issue_fire;
   logic       done_fire;

   // Strobes are only produced when enabled and out of reset.
   assign active   = rdy && !rst;

   // Flush blocks new fetch/load acceptance; stores are unaffected.
   assign fet_elig = bus.fet_req_valid && !flush;
   assign ld_elig  = bus.ld_req_valid  && !flush;

   mem_arb_pick u_pick (
      .fet_valid (fet_elig),
      .ld_valid  (ld_elig),
      .st_valid  (bus.st_req_valid),
      .starve    (starve),
      .grant     (gnt)
   );

   assign idle_arb = (state_q == ST_IDLE) && (|gnt);

   // A flush cancels the transaction in flight unless it is a store.
   assign kill       = flush && (kind_q != KIND_STORE);
   assign issue_fire = active && (state_q == ST_ISSUE) && !bus.mem_busy && !kill;
   assign done_fire  = active && (state_q == ST_WAIT)  && bus.mem_done  && !kill;

   assign bus.fet_req_ready = active && idle_arb && gnt[GNT_FET];
   assign bus.ld_req_ready  = active && idle_arb && gnt[GNT_LD];
   assign bus.st_req_ready  = active && idle_arb && gnt[GNT_ST];

   assign bus.arb_mem_valid = issue_fire;
   assign bus.arb_mem_kind  = kind_q;
   assign bus.arb_mem_size  = size_q;
   assign bus.arb_mem_addr  = addr_q;
   assign bus.arb_mem_data  = data_q;
   assign bus.arb_mem_id    = id_q;
   assign bus.arb_owner     = kind_q;

   assign bus.fet_done = done_fire && (kind_q == KIND_FETCH);
   assign bus.ld_done  = done_fire && (kind_q == KIND_LOAD);
   assign bus.st_done  = done_fire && (kind_q == KIND_STORE);

   // ---------------------------------------------------------------------------
   // Transaction FSM and latched request fields
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (rst) begin
         state_q <= ST_IDLE;
         kind_q  <= KIND_FETCH;
         size_q  <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         id_q    <= '0;
      end else if (rdy) begin
         unique case (state_q)
            ST_IDLE: begin
               if (gnt[GNT_ST]) begin
                  state_q <= ST_ISSUE;
                  kind_q  <= KIND_STORE;
                  size_q  <= bus.st_req_size;
                  addr_q  <= bus.st_req_addr;
                  data_q  <= bus.st_req_data;
                  id_q    <= '0;
               end else if (gnt[GNT_LD]) begin
                  state_q <= ST_ISSUE;
                  kind_q  <= KIND_LOAD;
                  size_q  <= bus.ld_req_size;
                  addr_q  <= bus.ld_req_addr;
                  data_q  <= '0;
                  id_q    <= bus.ld_req_id;
               end else if (gnt[GNT_FET]) begin
                  state_q <= ST_ISSUE;
                  kind_q  <= KIND_FETCH;
                  size_q  <= SIZE_WORD;
                  addr_q  <= bus.fet_req_addr;
                  data_q  <= '0;
                  id_q    <= '0;
               end
            end
            ST_ISSUE: begin
               // A cancelled fetch/load is dropped before it ever reaches memory.
               if (kill) begin
                  state_q <= ST_IDLE;
               end else if (!bus.mem_busy) begin
                  state_q <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               // mem_done ends the transaction even when a flush coincides;
               // the done pulse is suppressed combinationally in that case.
               if (bus.mem_done) begin
                  state_q <= ST_IDLE;
               end else if (kill) begin
                  state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (bus.mem_done) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Fetch anti-starvation guard
   // ---------------------------------------------------------------------------
`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   logic [CNT_W-1:0] starve_cnt_q;

   assign starve = (starve_cnt_q >= CNT_W'(STARVE_LIMIT));

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt_q <= '0;
      end else if (rdy) begin
         if (flush) begin
            starve_cnt_q <= '0;
         end else if (idle_arb) begin
            if (gnt[GNT_FET]) begin
               starve_cnt_q <= '0;
            end else if (bus.fet_req_valid && (starve_cnt_q != CNT_W'(STARVE_LIMIT))) begin
               starve_cnt_q <= starve_cnt_q + 1'b1;
            end
         end
      end
   end
`else
   // Fixed priority: the flag folds to constant 0 for any legal limit.
   assign starve = (STARVE_LIMIT < 0);
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_req_arbiter
// Self-checking bench for mem_req_arbiter. A transaction-level reference model
// (free / pending / issued / orphaned) predicts every strobe and latched field
// each cycle; directed sequences cover the documented scenarios and a random
// phase with a small memory-controller model exercises the rest.
// Define MEM_ARB_STARVE_GUARD_EN to also exercise the starvation guard.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_req_arbiter;
   import mem_arb_pkg::*;

   localparam int ROB_W = 4;
   localparam int LIMIT = 2;
`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst, rdy, flush;

   always #5 clk = ~clk;

   mem_req_arbiter_if #(.ROB_W(ROB_W)) bus ();

   mem_req_arbiter #(.STARVE_LIMIT(LIMIT), .ROB_W(ROB_W)) dut (
      .clk   (clk),
      .rst   (rst),
      .rdy   (rdy),
      .flush (flush),
      .bus   (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: one transaction record plus the fetch loss count
   // ---------------------------------------------------------------------------
   typedef enum {M_FREE, M_PEND, M_ISSUED, M_ORPHAN} mphase_e;

   mphase_e          m_phase = M_FREE;
   logic [1:0]       m_kind  = 2'b00;
   logic [1:0]       m_size  = 2'b00;
   logic [31:0]      m_addr  = '0;
   logic [31:0]      m_data  = '0;
   logic [ROB_W-1:0] m_id    = '0;
   int               m_losses = 0;
   int               m_win;
   logic             exp_valid;

   // Memory-controller stimulus model for the random phase.
   bit env_out = 1'b0;
   int env_cnt = 0;

   // Returns the kind code of the requester that should win, or -1.
   function automatic int winner();
      bit f, l, s;
      f = bus.fet_req_valid && !flush;
      l = bus.ld_req_valid  && !flush;
      s = bus.st_req_valid;
      if (GUARD && f && (m_losses >= LIMIT)) return 0;
      if (s) return 2;
      if (l) return 1;
      if (f) return 0;
      return -1;
   endfunction

   // Wait for the falling edge and compare every output against the model.
   task automatic settle();
      logic [2:0] e_rdy;
      logic [2:0] e_done;
      bit live, drop;
      @(negedge clk);
      e_rdy     = '0;
      e_done    = '0;
      exp_valid = 1'b0;
      m_win     = -1;
      live = !rst && rdy;
      drop = flush && (m_kind != 2'b10);
      if (live) begin
         case (m_phase)
            M_FREE: begin
               m_win = winner();
               if (m_win >= 0) e_rdy[m_win] = 1'b1;
            end
            M_PEND:   exp_valid = !drop && !bus.mem_busy;
            M_ISSUED: if (bus.mem_done && !drop) e_done[m_kind] = 1'b1;
            default: ;
         endcase
      end
      check("fet_req_ready", bus.fet_req_ready, e_rdy[0]);
      check("ld_req_ready",  bus.ld_req_ready,  e_rdy[1]);
      check("st_req_ready",  bus.st_req_ready,  e_rdy[2]);
      check("arb_mem_valid", bus.arb_mem_valid, exp_valid);
      check("fet_done",      bus.fet_done,      e_done[0]);
      check("ld_done",       bus.ld_done,       e_done[1]);
      check("st_done",       bus.st_done,       e_done[2]);
      check("arb_mem_kind",  bus.arb_mem_kind,  m_kind);
      check("arb_owner",     bus.arb_owner,     m_kind);
      check("arb_mem_size",  bus.arb_mem_size,  m_size);
      check("arb_mem_addr",  bus.arb_mem_addr,  m_addr);
      check("arb_mem_data",  bus.arb_mem_data,  m_data);
      check("arb_mem_id",    bus.arb_mem_id,    m_id);
   endtask

   task automatic m_clear();
      m_phase  = M_FREE;
      m_kind   = 2'b00;
      m_size   = 2'b00;
      m_addr   = '0;
      m_data   = '0;
      m_id     = '0;
      m_losses = 0;
   endtask

   // Apply the clock edge to the model, then let the DUT take it.
   task automatic advance();
      bit drop;
      drop = flush && (m_kind != 2'b10);
      if (rst) begin
         m_clear();
      end else if (rdy) begin
         if (flush) m_losses = 0;
         else if (m_phase == M_FREE && m_win >= 0) begin
            if (m_win == 0) m_losses = 0;
            else if (bus.fet_req_valid && m_losses < LIMIT) m_losses++;
         end
         case (m_phase)
            M_FREE: if (m_win >= 0) begin
               m_kind  = 2'(m_win);
               m_phase = M_PEND;
               case (m_win)
                  0: begin m_size = 2'b11; m_addr = bus.fet_req_addr; m_data = '0; m_id = '0; end
                  1: begin m_size = bus.ld_req_size; m_addr = bus.ld_req_addr; m_data = '0; m_id = bus.ld_req_id; end
                  default: begin m_size = bus.st_req_size; m_addr = bus.st_req_addr; m_data = bus.st_req_data; m_id = '0; end
               endcase
            end
            M_PEND:   if (drop) m_phase = M_FREE; else if (!bus.mem_busy) m_phase = M_ISSUED;
            M_ISSUED: if (bus.mem_done) m_phase = M_FREE; else if (drop) m_phase = M_ORPHAN;
            M_ORPHAN: if (bus.mem_done) m_phase = M_FREE;
            default: ;
         endcase
      end
      @(posedge clk);
      #1;
   endtask

   task automatic cyc();
      settle();
      advance();
   endtask

   task automatic quiet();
      rst = 1'b0; rdy = 1'b1; flush = 1'b0;
      bus.fet_req_valid = 1'b0; bus.fet_req_addr = '0;
      bus.ld_req_valid = 1'b0; bus.ld_req_size = '0; bus.ld_req_addr = '0; bus.ld_req_id = '0;
      bus.st_req_valid = 1'b0; bus.st_req_size = '0; bus.st_req_addr = '0; bus.st_req_data = '0;
      bus.mem_busy = 1'b0; bus.mem_done = 1'b0;
   endtask

   // Reset with all requests raised: nothing may be accepted while rst is high.
   task automatic do_reset();
      quiet();
      rst = 1'b1;
      bus.fet_req_valid = 1'b1; bus.ld_req_valid = 1'b1; bus.st_req_valid = 1'b1;
      settle();
      check("rst_st_ready", bus.st_req_ready, 1'b0);
      advance();
      quiet();
      settle();
      check("rst_state", dut.state_q, ST_IDLE);
      check("rst_addr", bus.arb_mem_addr, 32'h0);
      advance();
   endtask

   initial begin
      quiet();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      m_clear();
      do_reset();

      // --- all three valid: store first, then load ----------------------------
      bus.st_req_valid = 1'b1; bus.st_req_addr = 32'h2000; bus.st_req_size = SIZE_WORD;
      bus.st_req_data = 32'hDEAD_BEEF;
      bus.ld_req_valid = 1'b1; bus.ld_req_addr = 32'h3000; bus.ld_req_size = SIZE_HALF; bus.ld_req_id = 4'd5;
      bus.fet_req_valid = 1'b1; bus.fet_req_addr = 32'h4000;
      settle();
      check("prio_st", bus.st_req_ready, 1'b1);
      check("prio_ld", bus.ld_req_ready, 1'b0);
      check("prio_fet", bus.fet_req_ready, 1'b0);
      advance();
      bus.st_req_valid = 1'b0;
      settle();
      check("st_issue", bus.arb_mem_valid, 1'b1);
      check("st_kind", bus.arb_mem_kind, 32'h2);
      check("st_data", bus.arb_mem_data, 32'hDEAD_BEEF);
      advance();
      bus.mem_done = 1'b1;
      settle();
      check("st_done_pulse", bus.st_done, 1'b1);
      check("no_accept_on_done", bus.ld_req_ready, 1'b0);
      advance();
      bus.mem_done = 1'b0;
      settle();
      check("ld_next", bus.ld_req_ready, 1'b1);
      advance();
      bus.ld_req_valid = 1'b0; bus.fet_req_valid = 1'b0;
      cyc();
      bus.mem_done = 1'b1;
      cyc();
      bus.mem_done = 1'b0;

      // --- load word with memory busy for two cycles --------------------------
      do_reset();
      bus.ld_req_valid = 1'b1; bus.ld_req_addr = 32'h1000; bus.ld_req_size = SIZE_WORD; bus.ld_req_id = 4'd3;
      settle();
      check("ld_accept", bus.ld_req_ready, 1'b1);
      advance();
      bus.ld_req_valid = 1'b0;
      bus.mem_busy = 1'b1;
      settle(); check("busy_c1", bus.arb_mem_valid, 1'b0); advance();
      settle(); check("busy_c2", bus.arb_mem_valid, 1'b0); advance();
      bus.mem_busy = 1'b0;
      settle();
      check("ld_issue_c3", bus.arb_mem_valid, 1'b1);
      check("ld_addr", bus.arb_mem_addr, 32'h1000);
      check("ld_size", bus.arb_mem_size, 32'h3);
      check("ld_id", bus.arb_mem_id, 32'h3);
      advance();
      bus.mem_done = 1'b1;
      settle(); check("ld_done_pulse", bus.ld_done, 1'b1); advance();
      bus.mem_done = 1'b0;

      // --- fetch flushed in WAIT, done 4 cycles later --------------------------
      bus.fet_req_valid = 1'b1; bus.fet_req_addr = 32'h0000_0100;
      cyc();
      bus.fet_req_valid = 1'b0;
      settle(); check("fet_issue", bus.arb_mem_valid, 1'b1); check("fet_size", bus.arb_mem_size, 32'h3); advance();
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      settle(); check("drain_state", dut.state_q, ST_DRAIN); advance();
      cyc(); cyc();
      bus.mem_done = 1'b1;
      settle(); check("drain_no_done", bus.fet_done, 1'b0); advance();
      bus.mem_done = 1'b0;
      settle(); check("drain_to_idle", dut.state_q, ST_IDLE); advance();

      // --- store in WAIT is not cancelled by flush ----------------------------
      bus.st_req_valid = 1'b1; bus.st_req_addr = 32'h5000; bus.st_req_size = SIZE_BYTE; bus.st_req_data = 32'h55;
      cyc();
      bus.st_req_valid = 1'b0;
      cyc();
      flush = 1'b1;
      cyc();
      bus.mem_done = 1'b1;
      settle(); check("st_flush_done", bus.st_done, 1'b1); advance();
      bus.mem_done = 1'b0; flush = 1'b0;

      // --- flush in IDLE blocks load, flush in ISSUE drops fetch --------------
      bus.ld_req_valid = 1'b1; flush = 1'b1;
      settle(); check("flush_idle_ld", bus.ld_req_ready, 1'b0); advance();
      bus.ld_req_valid = 1'b0; flush = 1'b0;
      bus.fet_req_valid = 1'b1; bus.fet_req_addr = 32'h200;
      cyc();
      bus.fet_req_valid = 1'b0; flush = 1'b1;
      settle(); check("flush_issue_drop", bus.arb_mem_valid, 1'b0); advance();
      flush = 1'b0;
      settle(); check("flush_issue_idle", dut.state_q, ST_IDLE); advance();

      // --- flush and mem_done together on a load ------------------------------
      bus.ld_req_valid = 1'b1; bus.ld_req_addr = 32'h600; bus.ld_req_id = 4'd9;
      cyc();
      bus.ld_req_valid = 1'b0;
      cyc();
      flush = 1'b1; bus.mem_done = 1'b1;
      settle(); check("flush_done_supp", bus.ld_done, 1'b0); advance();
      flush = 1'b0; bus.mem_done = 1'b0;
      settle(); check("flush_done_idle", dut.state_q, ST_IDLE); advance();

      // --- rdy low holds WAIT and swallows nothing ----------------------------
      bus.ld_req_valid = 1'b1; bus.ld_req_addr = 32'h700; bus.ld_req_id = 4'd1;
      cyc();
      bus.ld_req_valid = 1'b0;
      cyc();
      rdy = 1'b0; bus.mem_done = 1'b1;
      settle(); check("rdy_low_done", bus.ld_done, 1'b0); advance();
      settle(); check("rdy_low_hold", dut.state_q, ST_WAIT); advance();
      rdy = 1'b1;
      settle(); check("rdy_high_done", bus.ld_done, 1'b1); advance();
      bus.mem_done = 1'b0;

      // --- reset during WAIT, then a stray mem_done ---------------------------
      bus.ld_req_valid = 1'b1; bus.ld_req_addr = 32'h800; bus.ld_req_id = 4'd7;
      cyc();
      bus.ld_req_valid = 1'b0;
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0; bus.mem_done = 1'b1;
      settle();
      check("stray_no_done", bus.ld_done, 1'b0);
      check("stray_id_zero", bus.arb_mem_id, 32'h0);
      advance();
      bus.mem_done = 1'b0;
      settle(); check("stray_idle", dut.state_q, ST_IDLE); advance();

`ifdef MEM_ARB_STARVE_GUARD_EN
      // --- starvation guard: fetch wins the third arbitration -----------------
      do_reset();
      bus.ld_req_valid = 1'b1; bus.ld_req_addr = 32'h900; bus.ld_req_id = 4'd2;
      bus.fet_req_valid = 1'b1; bus.fet_req_addr = 32'hA00;
      for (int a = 1; a <= 3; a++) begin
         settle();
         check($sformatf("starve_arb%0d_fet", a), bus.fet_req_ready, (a == 3));
         check($sformatf("starve_arb%0d_ld", a), bus.ld_req_ready, (a != 3));
         advance();
         cyc();
         bus.mem_done = 1'b1;
         cyc();
         bus.mem_done = 1'b0;
      end
      quiet();
`endif

      // --- randomized traffic --------------------------------------------------
      do_reset();
      env_out = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         rst   = ($urandom_range(0, 149) == 0);
         rdy   = ($urandom_range(0, 9) != 0);
         flush = ($urandom_range(0, 11) == 0);
         bus.fet_req_valid = $urandom_range(0, 1);
         bus.fet_req_addr  = $urandom;
         bus.ld_req_valid  = ($urandom_range(0, 2) == 0);
         bus.ld_req_addr   = $urandom;
         bus.ld_req_size   = ($urandom_range(0, 2) == 2) ? SIZE_WORD : 2'($urandom_range(0, 1));
         bus.ld_req_id     = ROB_W'($urandom);
         bus.st_req_valid  = ($urandom_range(0, 3) == 0);
         bus.st_req_addr   = $urandom;
         bus.st_req_size   = ($urandom_range(0, 2) == 2) ? SIZE_WORD : 2'($urandom_range(0, 1));
         bus.st_req_data   = $urandom;
         bus.mem_busy      = ($urandom_range(0, 3) == 0);
         if (env_out) bus.mem_done = (env_cnt == 0) && rdy;
         else         bus.mem_done = ($urandom_range(0, 24) == 0);
         settle();
         if (rst) begin
            env_out = 1'b0;
         end else if (rdy) begin
            if (env_out) begin
               if (bus.mem_done) env_out = 1'b0;
               else if (env_cnt > 0) env_cnt--;
            end
            if (exp_valid) begin
               env_out = 1'b1;
               env_cnt = $urandom_range(0, 4);
            end
         end
         advance();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_req_arbiter.md
MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- STARVE_LIMIT, 8: consecutive lost fetch arbitrations before fetch is forced to win.
- ROB_W, 4: width of the load ROB tag.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk  in  1  clock; the block has one clock.
- rst  in  1  reset; synchronous, active-high.
- rdy  in  1  global enable; all state holds when low.
- flush  in  1  pipeline flush.
- fet_req_valid/fet_req_addr  in  1/32  fetch request and PC.
- fet_req_ready  out  1  fetch accepted this cycle.
- ld_req_valid/ld_req_size/ld_req_addr/ld_req_id  in  1/2/32/ROB_W  load request.
- ld_req_ready  out  1  load accepted this cycle.
- st_req_valid/st_req_size/st_req_addr/st_req_data  in  1/2/32/32  committed store request.
- st_req_ready  out  1  store accepted this cycle.
- arb_mem_valid  out  1  one-cycle issue strobe to the memory controller.
- arb_mem_kind/arb_mem_size  out  2/2  transaction kind and size.
- arb_mem_addr/arb_mem_data/arb_mem_id  out  32/32/ROB_W  latched request fields.
- mem_busy  in  1  memory controller cannot take an issue.
- mem_done  in  1  one-cycle pulse: the current transaction has finished.
- fet_done/ld_done/st_done  out  1  one-cycle completion pulse to the owning requester.
- arb_owner  out  2  kind of the transaction in flight; valid when not IDLE.

Function
REQ-003 FSM states: IDLE, ISSUE, WAIT, DRAIN.
REQ-004 Arbitration is evaluated in IDLE only. Fixed priority: store > load > fetch.
REQ-005 In IDLE, exactly one *_req_ready goes high for the winner in the same cycle as its valid. Request fields are latched and the FSM moves to ISSUE.
REQ-006 In ISSUE, arb_mem_valid = 1 for exactly one cycle, in the first cycle with mem_busy = 0; the FSM then moves to WAIT. The earliest issue is 1 cycle after acceptance.
REQ-007 In WAIT, mem_done pulses the owner's *_done in the same cycle and returns the FSM to IDLE. No new request is accepted in that cycle.
REQ-008 mem_done in IDLE or ISSUE is ignored.
REQ-009 Encodings:
- kind: 00 fetch, 01 load, 10 store.
- size: 00 byte, 01 half, 11 word.
- Fetch always issues size 11.
REQ-010 arb_mem_data is 0 for non-store kinds. arb_mem_id is 0 for non-load kinds.
REQ-011 flush in IDLE: fet_req_ready and ld_req_ready are forced to 0 that cycle. st_req_ready is unaffected.
REQ-012 flush in ISSUE with owner fetch or load: the request is dropped without issue, no done pulse, FSM goes to IDLE.
REQ-013 flush in WAIT with owner fetch or load: FSM goes to DRAIN and waits for mem_done with the done pulse suppressed, then goes to IDLE.
- If flush and mem_done coincide, the done pulse is suppressed and the FSM goes directly to IDLE.
REQ-014 Store transactions are never cancelled by flush.
REQ-015 When rdy = 0, outputs and state hold. Done and valid pulses are not repeated.

Reset
REQ-016 rst is sampled on clk and takes precedence over rdy and flush.
REQ-017 On reset:
- state = IDLE; starvation counter = 0.
- All ready, valid and done outputs = 0.
- arb_owner, arb_mem_kind, arb_mem_size, arb_mem_addr, arb_mem_data and arb_mem_id = 0.
REQ-018 Reset asserted mid-transaction abandons it silently. A mem_done arriving after reset is ignored.

Configuration
REQ-019 Macro MEM_ARB_STARVE_GUARD_EN.
REQ-020 With the macro defined:
- An IDLE arbitration in which fet_req_valid = 1 and fetch loses increments a saturating counter.
- When the counter is at or above STARVE_LIMIT, fetch outranks load and store.
- The counter clears when fetch is granted or on flush.
REQ-021 Without the macro: strict priority per REQ-004, and no counter exists.

Structure
REQ-022 Package mem_arb_pkg holds the kind codes, size codes, FSM state encoding and the default STARVE_LIMIT.
REQ-023 One sub-module, mem_arb_pick: a combinational priority select that takes the three valids and the starve flag and returns a one-hot grant.

Verification
REQ-024 Store, load and fetch valid together in IDLE -> st_req_ready only. Issue kind 10. After mem_done, st_done; then load is granted next.
REQ-025 Load word at 0x1000, id 3, with mem_busy high for 2 cycles -> arb_mem_valid in cycle 3 after acceptance, addr 0x1000, size 11, id 3; then ld_done on mem_done.
REQ-026 Fetch in WAIT, flush asserted, mem_done 4 cycles later -> state DRAIN, no fet_done, IDLE after mem_done.
REQ-027 Store in WAIT with flush -> st_done still pulses on mem_done.
REQ-028 MEM_ARB_STARVE_GUARD_EN defined, STARVE_LIMIT = 2, loads continuously valid alongside fetch -> fetch granted on the third arbitration.
REQ-029 rst during WAIT followed by a stray mem_done -> no done pulse, outputs 0, FSM remains IDLE.
